// File: rtl/mem_responder_if.sv
// Core-side memory port: request/grant for commands, recv/ack for responses.
interface mem_responder_if;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_recv;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
    input  mem_gnt, mem_recv, mem_error, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
    output mem_gnt, mem_recv, mem_error, mem_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with bounded pseudo-random grant/response stalls.
// Define MEM_RESPONDER_ERROR_EN to flag out-of-range accesses instead of wrapping.
//
// state    | meaning
// RSP_IDLE | no response presented, mem_recv low
// RSP_SHOW | head response presented, held stable until acked
module mem_responder #(
  parameter int          MEM_WORDS     = 1024,
  parameter int          DEPTH         = 4,
  parameter int          MAX_GNT_STALL = 3,
  parameter int          MAX_RSP_STALL = 3,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {
    RSP_IDLE = 1'b0,
    RSP_SHOW = 1'b1
  } rsp_state_t;

  rsp_state_t  state;
  logic [15:0] lfsr;
  logic [4:0]  gnt_stall;
  logic [4:0]  rsp_stall;
  logic [PW:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [31:0] q_rdata [DEPTH];
  logic        q_error [DEPTH];
  logic [31:0] ram [MEM_WORDS];

  logic        full;
  logic        gnt_ok;
  logic        rsp_ok;
  logic        push;
  logic        pop;
  logic        wr_ok;
  logic [AW-1:0] idx;
  logic [31:0] push_rdata;
  logic        push_error;
  logic        next_avail;
  logic [31:0] next_rdata;
  logic        next_error;
  logic        unused_bits;

  assign full    = (count == (PW+1)'(DEPTH));
  assign gnt_ok  = (gnt_stall == 5'(MAX_GNT_STALL)) || !lfsr[0];
  assign rsp_ok  = (rsp_stall == 5'(MAX_RSP_STALL)) || !lfsr[1];
  assign bus.mem_gnt = !reset && bus.mem_req && !full && gnt_ok;
  assign push    = bus.mem_gnt;
  assign pop     = (state == RSP_SHOW) && bus.mem_ack;
  assign idx     = bus.mem_addr[AW+1:2];
  assign rd_next = rd_ptr + 1'b1;

`ifdef MEM_RESPONDER_ERROR_EN
  logic in_range;
  assign in_range    = ({2'b00, bus.mem_addr[31:2]} < 32'(MEM_WORDS));
  assign wr_ok       = push && bus.mem_wen && in_range;
  assign push_error  = !in_range;
  assign push_rdata  = (bus.mem_wen || !in_range) ? 32'h0 : ram[idx];
  assign unused_bits = ^bus.mem_addr[1:0];
`else
  assign wr_ok       = push && bus.mem_wen;
  assign push_error  = 1'b0;
  assign push_rdata  = bus.mem_wen ? 32'h0 : ram[idx];
  assign unused_bits = ^{bus.mem_addr[31:AW+2], bus.mem_addr[1:0]};
`endif

  // Next response candidate; an empty queue bypasses the pushed entry so a
  // grant in one cycle can be answered in the next.
  always_comb begin
    next_avail = 1'b0;
    next_rdata = push_rdata;
    next_error = push_error;
    if (state == RSP_IDLE) begin
      if (count != '0) begin
        next_avail = 1'b1;
        next_rdata = q_rdata[rd_ptr];
        next_error = q_error[rd_ptr];
      end else if (push) begin
        next_avail = 1'b1;
      end
    end else if (pop) begin
      if (count > (PW+1)'(1)) begin
        next_avail = 1'b1;
        next_rdata = q_rdata[rd_next];
        next_error = q_error[rd_next];
      end else if (push) begin
        next_avail = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_strb[i]) ram[idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_rdata[wr_ptr] <= push_rdata;
      q_error[wr_ptr] <= push_error;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr      <= SEED;
      gnt_stall <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (!bus.mem_req || bus.mem_gnt) begin
        gnt_stall <= '0;
      end else if (!full && gnt_stall != 5'(MAX_GNT_STALL)) begin
        gnt_stall <= gnt_stall + 5'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RSP_IDLE;
      bus.mem_recv  <= 1'b0;
      bus.mem_rdata <= '0;
      bus.mem_error <= 1'b0;
      rsp_stall     <= '0;
    end else begin
      case (state)
        RSP_IDLE: begin
          if (next_avail && rsp_ok) begin
            state         <= RSP_SHOW;
            bus.mem_recv  <= 1'b1;
            bus.mem_rdata <= next_rdata;
            bus.mem_error <= next_error;
            rsp_stall     <= '0;
          end else if (count == '0) begin
            rsp_stall <= '0;
          end else if (rsp_stall != 5'(MAX_RSP_STALL)) begin
            rsp_stall <= rsp_stall + 5'd1;
          end
        end
        RSP_SHOW: begin
          if (pop) begin
            if (next_avail && rsp_ok) begin
              bus.mem_rdata <= next_rdata;
              bus.mem_error <= next_error;
            end else begin
              state        <= RSP_IDLE;
              bus.mem_recv <= 1'b0;
            end
            rsp_stall <= '0;
          end
        end
        default: begin
          state        <= RSP_IDLE;
          bus.mem_recv <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: zero-stall vectors, queue-full and reset sequences,
// and a long random run against a scoreboard on a randomly stalling instance.
module tb_mem_responder;

  localparam int DEPTH = 4;
  localparam int MAXG  = 3;

`ifdef MEM_RESPONDER_ERROR_EN
  localparam logic [31:0] W1_VAL = 32'h55555555;
`else
  localparam logic [31:0] W1_VAL = 32'h55555678;
`endif

  typedef struct {
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  mem_responder_if bus0();
  mem_responder_if bus1();

  mem_responder #(.MEM_WORDS(1024), .DEPTH(DEPTH), .MAX_GNT_STALL(MAXG),
                  .MAX_RSP_STALL(3), .SEED(16'h0000)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0));

  mem_responder #(.MEM_WORDS(1024), .DEPTH(DEPTH), .MAX_GNT_STALL(MAXG),
                  .MAX_RSP_STALL(3), .SEED(16'hACE1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  vec_t        vecs [11];
  rsp_t        sb0 [$];
  rsp_t        sb1 [$];
  logic [31:0] mem1 [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic req, input logic wen, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic ack);
    bus0.mem_req   = req;
    bus0.mem_wen   = wen;
    bus0.mem_strb  = strb;
    bus0.mem_addr  = addr;
    bus0.mem_wdata = wdata;
    bus0.mem_ack   = ack;
  endtask

  // Call at the sampling point; retires one response of dut0 if handshaken.
  task automatic check_rsp0(input string name);
    rsp_t r;
    if (bus0.mem_recv && bus0.mem_ack) begin
      if (sb0.size() == 0) begin
        chk({name, " unexpected rsp"}, 32'(bus0.mem_recv), 32'd0);
      end else begin
        r = sb0.pop_front();
        chk({name, " rdata"}, bus0.mem_rdata, r.d);
        chk({name, " error"}, 32'(bus0.mem_error), 32'(r.e));
      end
    end
  endtask

  initial begin
    logic [31:0] qaddr [5];
    logic [31:0] qexp [5];
    int          n_req;
    int          cyc;
    int          stall;
    logic        pend;
    logic        full_b;
    logic [31:0] exp_d;
    logic [5:0]  widx;
    rsp_t        r;

    vecs[0]  = '{1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 4'hF, 32'h20,   32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 4'h5, 32'h20,   32'hAABBCCDD, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 4'h0, 32'h20,   32'h0,        32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 4'hF, 32'h0,    32'hCAFEF00D, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 4'hF, 32'h4,    32'h55555555, 32'h0,        1'b0};
`ifdef MEM_RESPONDER_ERROR_EN
    vecs[7]  = '{1'b1, 4'h3, 32'h1004, 32'h12345678, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 4'h0, 32'h1000, 32'h0,        32'h0,        1'b1};
`else
    vecs[7]  = '{1'b1, 4'h3, 32'h1004, 32'h12345678, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 4'h0, 32'h1000, 32'h0,        32'hCAFEF00D, 1'b0};
`endif
    vecs[9]  = '{1'b0, 4'h0, 32'h4,    32'h0,        W1_VAL,       1'b0};
    vecs[10] = '{1'b0, 4'hF, 32'h7,    32'hFFFFFFFF, W1_VAL,       1'b0};

    qaddr[0] = 32'h10; qexp[0] = 32'hDEADBEEF;
    qaddr[1] = 32'h20; qexp[1] = 32'h11BB33DD;
    qaddr[2] = 32'h0;  qexp[2] = 32'hCAFEF00D;
    qaddr[3] = 32'h4;  qexp[3] = W1_VAL;
    qaddr[4] = 32'h10; qexp[4] = 32'hDEADBEEF;

    drive0(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    bus1.mem_req = 1'b1; bus1.mem_wen = 1'b0; bus1.mem_strb = 4'h0;
    bus1.mem_addr = 32'h0; bus1.mem_wdata = 32'h0; bus1.mem_ack = 1'b0;

    // Reset state, with requests held to show grant is suppressed in reset.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset gnt0",   32'(bus0.mem_gnt),   32'd0);
    chk("reset recv0",  32'(bus0.mem_recv),  32'd0);
    chk("reset err0",   32'(bus0.mem_error), 32'd0);
    chk("reset rdata0", bus0.mem_rdata,      32'd0);
    chk("reset gnt1",   32'(bus1.mem_gnt),   32'd0);
    chk("reset recv1",  32'(bus1.mem_recv),  32'd0);
    tick();
    reset = 1'b0;
    drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    bus1.mem_req = 1'b0;
    tick();

    // Zero-stall vectors: grant in the request cycle, response one cycle later.
    for (int i = 0; i < 11; i++) begin
      drive0(1'b1, vecs[i].wen, vecs[i].strb, vecs[i].addr, vecs[i].wdata, 1'b0);
      @(negedge clock);
      chk($sformatf("vec%0d gnt", i), 32'(bus0.mem_gnt), 32'd1);
      chk($sformatf("vec%0d early recv", i), 32'(bus0.mem_recv), 32'd0);
      if (bus0.mem_gnt) sb0.push_back('{vecs[i].rdata, vecs[i].err});
      tick();
      drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      @(negedge clock);
      chk($sformatf("vec%0d recv", i), 32'(bus0.mem_recv), 32'd1);
      check_rsp0($sformatf("vec%0d", i));
      tick();
      bus0.mem_ack = 1'b0;
    end
    sb0.delete();

    // Queue full: four granted, fifth held until one ack frees a slot.
    for (int k = 0; k < 4; k++) begin
      drive0(1'b1, 1'b0, 4'h0, qaddr[k], 32'h0, 1'b0);
      @(negedge clock);
      chk($sformatf("qfull gnt%0d", k), 32'(bus0.mem_gnt), 32'd1);
      if (bus0.mem_gnt) sb0.push_back('{qexp[k], 1'b0});
      if (k > 0) begin
        chk($sformatf("qfull recv%0d", k), 32'(bus0.mem_recv), 32'd1);
        chk($sformatf("qfull rdata%0d", k), bus0.mem_rdata, qexp[0]);
      end
      tick();
    end
    drive0(1'b1, 1'b0, 4'h0, qaddr[4], 32'h0, 1'b0);
    @(negedge clock);
    chk("qfull fifth held", 32'(bus0.mem_gnt), 32'd0);
    chk("qfull stable rdata", bus0.mem_rdata, qexp[0]);
    tick();
    bus0.mem_ack = 1'b1;
    @(negedge clock);
    chk("qfull gnt at pop", 32'(bus0.mem_gnt), 32'd0);
    check_rsp0("qfull pop");
    tick();
    bus0.mem_ack = 1'b0;
    @(negedge clock);
    chk("qfull gnt after ack", 32'(bus0.mem_gnt), 32'd1);
    if (bus0.mem_gnt) sb0.push_back('{qexp[4], 1'b0});
    chk("qfull next head recv", 32'(bus0.mem_recv), 32'd1);
    chk("qfull next head rdata", bus0.mem_rdata, qexp[1]);
    tick();
    drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    for (int c = 0; c < 12 && sb0.size() != 0; c++) begin
      @(negedge clock);
      check_rsp0("qfull drain");
      tick();
    end
    chk("qfull drained", 32'(sb0.size()), 32'd0);
    bus0.mem_ack = 1'b0;
    sb0.delete();
    tick();

    // Reset with three responses queued and recv high.
    for (int k = 0; k < 3; k++) begin
      drive0(1'b1, 1'b0, 4'h0, qaddr[k], 32'h0, 1'b0);
      @(negedge clock);
      chk($sformatf("rst fill gnt%0d", k), 32'(bus0.mem_gnt), 32'd1);
      tick();
    end
    drive0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst recv before", 32'(bus0.mem_recv), 32'd1);
    chk("rst gnt in reset", 32'(bus0.mem_gnt), 32'd0);
    tick();
    reset = 1'b0;
    drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    chk("rst recv after", 32'(bus0.mem_recv), 32'd0);
    chk("rst gnt after", 32'(bus0.mem_gnt), 32'd0);
    tick();
    drive0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    @(negedge clock);
    chk("rst new gnt", 32'(bus0.mem_gnt), 32'd1);
    if (bus0.mem_gnt) sb0.push_back('{32'hDEADBEEF, 1'b0});
    tick();
    drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clock);
    chk("rst new recv", 32'(bus0.mem_recv), 32'd1);
    check_rsp0("rst new");
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clock);
      chk($sformatf("rst no extra rsp%0d", c), 32'(bus0.mem_recv), 32'd0);
    end
    tick();
    bus0.mem_ack = 1'b0;

    // Random run on the stalling instance; first 64 requests fill the RAM window.
    n_req = 0;
    cyc   = 0;
    stall = 0;
    pend  = 1'b0;
    while ((n_req < 10000 || sb1.size() != 0) && cyc < 80000) begin
      if (!pend && n_req < 10000 && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        if (n_req < 64) begin
          bus1.mem_wen  = 1'b1;
          bus1.mem_strb = 4'hF;
          bus1.mem_addr = 32'(n_req) << 2;
        end else begin
          bus1.mem_wen  = 1'($urandom_range(0, 1));
          bus1.mem_strb = 4'($urandom_range(0, 15));
          bus1.mem_addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
        end
        bus1.mem_wdata = $urandom;
      end
      bus1.mem_req = pend;
      bus1.mem_ack = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      full_b = (sb1.size() >= DEPTH);
      if (bus1.mem_recv) chk("rand recv with empty queue", 32'(sb1.size() == 0), 32'd0);
      if (bus1.mem_recv && bus1.mem_ack && sb1.size() != 0) begin
        r = sb1.pop_front();
        chk("rand rsp rdata", bus1.mem_rdata, r.d);
        chk("rand rsp error", 32'(bus1.mem_error), 32'(r.e));
      end
      if (bus1.mem_req) begin
        if (bus1.mem_gnt) begin
          chk("rand gnt while full", 32'(full_b), 32'd0);
          widx  = bus1.mem_addr[7:2];
          exp_d = bus1.mem_wen ? 32'h0 : mem1[widx];
          if (bus1.mem_wen) begin
            for (int b = 0; b < 4; b++)
              if (bus1.mem_strb[b]) mem1[widx][8*b +: 8] = bus1.mem_wdata[8*b +: 8];
          end
          sb1.push_back('{exp_d, 1'b0});
          stall = 0;
          n_req++;
          pend = 1'b0;
        end else if (!full_b) begin
          stall++;
          chk("rand gnt stall bound", 32'(stall > MAXG), 32'd0);
        end
      end else begin
        stall = 0;
      end
      tick();
      cyc++;
    end
    chk("rand all requests done", 32'(10000 - n_req), 32'd0);
    chk("rand all responses done", 32'(sb1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
